// File: rtl/arc_pipe_datapath_pkg.sv
// Shared definitions for the two-stage ARC datapath: ALU opcodes, FSM states, PSR bit positions.
package arc_dp_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_PASSA = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_INC   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2
    } state_t;

    localparam int PSR_Z = 0;
    localparam int PSR_N = 1;
    localparam int PSR_C = 2;
    localparam int PSR_V = 3;
    localparam int PSR_D = 4;

endpackage

// File: rtl/arc_pipe_datapath_if.sv
// Micro-op issue and memory port bundle; master is the control/memory side, slave is the datapath.
interface arc_pipe_datapath_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             op_valid;
    logic             op_ready;
    logic [AW-1:0]    op_addr_a;
    logic [AW-1:0]    op_addr_b;
    logic [AW-1:0]    op_addr_d;
    logic             op_rf_we;
    logic             op_sel_mem;
    logic             op_mem_we;
    logic             op_psr_we;
    logic             op_psr_d;
    logic [3:0]       op_opcode;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [4:0]       status;
    logic             busy;

    modport master (
        output op_valid, op_addr_a, op_addr_b, op_addr_d, op_rf_we, op_sel_mem,
               op_mem_we, op_psr_we, op_psr_d, op_opcode, mem_ack, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_addr, mem_wdata, status, busy
    );

    modport slave (
        input  op_valid, op_addr_a, op_addr_b, op_addr_d, op_rf_we, op_sel_mem,
               op_mem_we, op_psr_we, op_psr_d, op_opcode, mem_ack, mem_rdata,
        output op_ready, mem_req, mem_we, mem_addr, mem_wdata, status, busy
    );

endinterface

// File: rtl/arc_pipe_datapath_alu.sv
// Combinational ALU for the ARC datapath: result plus V/C/N/Z flags.
module arc_alu
    import arc_dp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [SW-1:0] sh;
    logic [WIDTH:0] sum;

    assign sh = b[SW-1:0];

    always_comb begin
        result = '0;
        sum    = '0;
        v      = 1'b0;
        c      = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            // Top bit of the widened difference is the borrow.
            OP_SUB: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOR:   result = ~(a | b);
            OP_SLL:   result = a << sh;
            OP_SRL:   result = a >> sh;
            OP_SRA:   result = $unsigned($signed(a) >>> sh);
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_INC: begin
                sum    = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = ~a[MSB] & result[MSB];
            end
            default: result = '0;
        endcase
    end

    assign n = result[MSB];
    assign z = (result == '0);

endmodule

// File: rtl/arc_pipe_datapath.sv
// Two-stage ARC datapath: operand read into an execute latch, then ALU/memory writeback and PSR update.
// Optional: define ARC_DP_FORWARD_EN to bypass the EXEC result into the operand latch instead of stalling.
module arc_pipe_datapath
    import arc_dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input logic               clk,
    input logic               reset,
    arc_pipe_datapath_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    state_t state, state_next;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] ex_a, ex_b;
    logic [AW-1:0]    ex_d;
    logic             ex_rf_we, ex_psr_we, ex_psr_d, ex_mem_we;
    logic [3:0]       ex_opcode;
    logic [4:0]       psr;

    logic [WIDTH-1:0] alu_result;
    logic             alu_v, alu_c, alu_n, alu_z;

    logic [WIDTH-1:0] rd_a, rd_b, opnd_a, opnd_b;
    logic             ex_wb, hazard_a, hazard_b, stall, ready, accept;

    arc_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (ex_a),
        .b      (ex_b),
        .opcode (ex_opcode),
        .result (alu_result),
        .v      (alu_v),
        .c      (alu_c),
        .n      (alu_n),
        .z      (alu_z)
    );

    assign rd_a = (bus.op_addr_a == '0) ? '0 : regs[bus.op_addr_a];
    assign rd_b = (bus.op_addr_b == '0) ? '0 : regs[bus.op_addr_b];

    // An op in EXEC that will write a real register this cycle is the only hazard source.
    assign ex_wb    = (state == ST_EXEC) && ex_rf_we && (ex_d != '0);
    assign hazard_a = ex_wb && (bus.op_addr_a == ex_d);
    assign hazard_b = ex_wb && (bus.op_addr_b == ex_d);

`ifdef ARC_DP_FORWARD_EN
    assign stall  = 1'b0;
    assign opnd_a = hazard_a ? alu_result : rd_a;
    assign opnd_b = hazard_b ? alu_result : rd_b;
`else
    assign stall  = hazard_a | hazard_b;
    assign opnd_a = rd_a;
    assign opnd_b = rd_b;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        ready         = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.op_valid) state_next = bus.op_sel_mem ? ST_MEM : ST_EXEC;
            end
            ST_EXEC: begin
                ready = ~stall;
                if (bus.op_valid && !stall) state_next = bus.op_sel_mem ? ST_MEM : ST_EXEC;
                else                        state_next = ST_IDLE;
            end
            ST_MEM: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = ex_mem_we;
                bus.mem_addr  = ex_a;
                bus.mem_wdata = ex_b;
                if (bus.mem_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept       = bus.op_valid && ready;
    assign bus.op_ready = ready;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.status   = psr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_a      <= '0;
            ex_b      <= '0;
            ex_d      <= '0;
            ex_rf_we  <= 1'b0;
            ex_psr_we <= 1'b0;
            ex_psr_d  <= 1'b0;
            ex_mem_we <= 1'b0;
            ex_opcode <= '0;
            psr       <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                ex_a      <= opnd_a;
                ex_b      <= opnd_b;
                ex_d      <= bus.op_addr_d;
                ex_rf_we  <= bus.op_rf_we;
                ex_psr_we <= bus.op_psr_we;
                ex_psr_d  <= bus.op_psr_d;
                ex_mem_we <= bus.op_sel_mem & bus.op_mem_we;
                ex_opcode <= bus.op_opcode;
            end
            if (ex_wb) regs[ex_d] <= alu_result;
            if ((state == ST_EXEC) && ex_psr_we) begin
                psr[PSR_D] <= ex_psr_d;
                psr[PSR_V] <= alu_v;
                psr[PSR_C] <= alu_c;
                psr[PSR_N] <= alu_n;
                psr[PSR_Z] <= alu_z;
            end
            // Only loads write back from memory; the PSR is left alone.
            if ((state == ST_MEM) && bus.mem_ack && !ex_mem_we && ex_rf_we && (ex_d != '0))
                regs[ex_d] <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_arc_pipe_datapath.sv
// Self-checking bench for arc_pipe_datapath: directed scenarios plus random ALU ops against a sequential model.
module tb_arc_pipe_datapath;
    import arc_dp_pkg::*;

    logic clk;
    logic reset;

    arc_pipe_datapath_if #(.WIDTH(16), .AW(4)) bus ();

    arc_pipe_datapath #(.WIDTH(16), .NREGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef ARC_DP_FORWARD_EN
    localparam int B2B_STALLS = 0;
`else
    localparam int B2B_STALLS = 1;
`endif

    int          tests_run;
    int          tests_failed;
    logic [15:0] model_regs [16];
    logic [4:0]  model_psr;
    int          mem_ready_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Spec-level ALU reference using integer arithmetic and signed range checks.
    function automatic void alu_ref(input int opc, input int a, input int b,
                                    output int res, output bit v, output bit c,
                                    output bit n, output bit z);
        int sa, sb, full, sh;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        sh = b % 16;
        v = 0; c = 0; res = 0;
        case (opc)
            0:  begin full = a + b; res = full % 65536; c = (full > 65535);
                      v = (sa + sb > 32767) || (sa + sb < -32768); end
            1:  begin res = (a - b + 65536) % 65536; c = (a < b);
                      v = (sa - sb > 32767) || (sa - sb < -32768); end
            2:  res = a & b;
            3:  res = a | b;
            4:  res = a ^ b;
            5:  res = (~(a | b)) & 65535;
            6:  res = (a << sh) & 65535;
            7:  res = a >> sh;
            8:  res = (sa >>> sh) & 65535;
            9:  res = a;
            10: res = b;
            11: begin full = a + 1; res = full % 65536; c = (full > 65535); v = (a == 32767); end
            default: res = 0;
        endcase
        n = (res >= 32768);
        z = (res == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
        model_psr = 5'b00000;
    endtask

    task automatic apply_stimulus(input logic [3:0] opc, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] d, input logic rf_we, input logic sel_mem,
                                  input logic mem_we, input logic psr_we, input logic psr_d,
                                  output int stalls);
        bus.op_valid   = 1'b1;
        bus.op_opcode  = opc;
        bus.op_addr_a  = a;
        bus.op_addr_b  = b;
        bus.op_addr_d  = d;
        bus.op_rf_we   = rf_we;
        bus.op_sel_mem = sel_mem;
        bus.op_mem_we  = mem_we;
        bus.op_psr_we  = psr_we;
        bus.op_psr_d   = psr_d;
        stalls = 0;
        #1;
        while (bus.op_ready !== 1'b1 && stalls < 20) begin
            @(posedge clk); #2;
            stalls++;
        end
        check_output("op_accept", 32'(bus.op_ready), 32'd1);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [3:0] opc, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic rf_we, input logic psr_we,
                          input logic psr_d, input int exp_stalls, input bit check_timing);
        int res, stalls;
        bit v, c, n, z;
        logic [4:0] psr_before;
        alu_ref(int'(opc), int'(model_regs[a]), int'(model_regs[b]), res, v, c, n, z);
        psr_before = model_psr;
        apply_stimulus(opc, a, b, d, rf_we, 1'b0, 1'b0, psr_we, psr_d, stalls);
        check_output("stall_count", 32'(stalls), 32'(exp_stalls));
        if (rf_we && d != 4'd0) model_regs[d] = res[15:0];
        if (psr_we) model_psr = {psr_d, v, c, n, z};
        if (check_timing) begin
            check_output("status_n1", 32'(bus.status), 32'(psr_before));
            @(posedge clk); #1;
            check_output("status_n2", 32'(bus.status), 32'(model_psr));
            check_output("busy_after_alu", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic mem_txn(input logic we, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input logic rf_we, input logic [15:0] rdata,
                           input int ack_delay, output logic [15:0] seen_addr,
                           output logic [15:0] seen_wdata);
        int stalls;
        logic [4:0] psr_before;
        psr_before = model_psr;
        apply_stimulus(OP_ADD, a, b, d, rf_we, 1'b1, we, 1'b0, 1'b0, stalls);
        mem_ready_low = 0;
        check_output("mem_req_assert", 32'(bus.mem_req), 32'd1);
        check_output("mem_we", 32'(bus.mem_we), 32'(we));
        check_output("mem_addr", 32'(bus.mem_addr), 32'(model_regs[a]));
        check_output("mem_wdata", 32'(bus.mem_wdata), 32'(model_regs[b]));
        seen_addr  = bus.mem_addr;
        seen_wdata = bus.mem_wdata;
        for (int i = 0; i < ack_delay; i++) begin
            if (bus.op_ready === 1'b0) mem_ready_low++;
            @(posedge clk); #1;
            check_output("mem_req_held", 32'(bus.mem_req), 32'd1);
            check_output("mem_addr_held", 32'(bus.mem_addr), 32'(seen_addr));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        #1;
        if (bus.op_ready === 1'b0) mem_ready_low++;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        check_output("mem_req_drop", 32'(bus.mem_req), 32'd0);
        check_output("mem_psr_kept", 32'(bus.status), 32'(psr_before));
        if (!we && rf_we && d != 4'd0) model_regs[d] = rdata;
    endtask

    logic [15:0] sa, sw;
    int          stalls_tmp;

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op_addr_a = '0;
        bus.op_addr_b = '0;
        bus.op_addr_d = '0;
        bus.op_rf_we  = 1'b0;
        bus.op_sel_mem = 1'b0;
        bus.op_mem_we = 1'b0;
        bus.op_psr_we = 1'b0;
        bus.op_psr_d  = 1'b0;
        bus.op_opcode = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_status", 32'(bus.status), 32'd0);
        check_output("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_output("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Load operands, then ADD with overflow into negative range.
        mem_txn(1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h7FFF, 0, sa, sw);
        mem_txn(1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 16'h0001, 1, sa, sw);
        alu_op(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        check_output("add_status", 32'(bus.status), 32'b01010);
        mem_txn(1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 16'h0000, 0, sa, sw);
        check_output("add_r3", 32'(sa), 32'h8000);

        alu_op(OP_SUB, 4'd2, 4'd2, 4'd7, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        check_output("sub_status", 32'(bus.status), 32'b10001);

        // Dependent back-to-back ADDs.
        alu_op(OP_ADD, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        alu_op(OP_ADD, 4'd4, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, B2B_STALLS, 1'b1);
        mem_txn(1'b1, 4'd5, 4'd4, 4'd0, 1'b0, 16'h0000, 0, sa, sw);
        check_output("b2b_r5", 32'(sa), 32'h8001);
        check_output("b2b_r4", 32'(sw), 32'h8000);

        // Slow load: address held, issue blocked for all four MEM cycles.
        mem_txn(1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0040, 0, sa, sw);
        mem_txn(1'b0, 4'd1, 4'd0, 4'd6, 1'b1, 16'hBEEF, 3, sa, sw);
        check_output("load_addr", 32'(sa), 32'h0040);
        check_output("load_ready_low", 32'(mem_ready_low), 32'd4);
        mem_txn(1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 16'h0000, 0, sa, sw);
        check_output("load_r6", 32'(sa), 32'hBEEF);

        // R0 stays zero for loads and ALU writes.
        mem_txn(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 16'h1234, 0, sa, sw);
        alu_op(OP_PASSA, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        mem_txn(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0000, 0, sa, sw);
        check_output("r0_zero", 32'(sa), 32'h0000);

        // Reset while a load is outstanding; a late ack must not write.
        mem_txn(1'b0, 4'd0, 4'd0, 4'd9, 1'b1, 16'h5A5A, 0, sa, sw);
        apply_stimulus(OP_ADD, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, stalls_tmp);
        check_output("rst_mid_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_output("rst_mid_drop", 32'(bus.mem_req), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        check_output("late_ack_busy", 32'(bus.busy), 32'd0);
        check_output("late_ack_status", 32'(bus.status), 32'd0);
        mem_txn(1'b1, 4'd9, 4'd0, 4'd0, 1'b0, 16'h0000, 0, sa, sw);
        check_output("late_ack_r9", 32'(sa), 32'h0000);

        // Random register contents and random ALU ops.
        for (int r = 1; r < 16; r++)
            mem_txn(1'b0, 4'd0, 4'd0, 4'(r), 1'b1, 16'($urandom), int'($urandom_range(0, 2)), sa, sw);
        for (int k = 0; k < 60; k++)
            alu_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'b1);
        for (int r = 0; r < 16; r += 2)
            mem_txn(1'b1, 4'(r), 4'(r + 1), 4'd0, 1'b0, 16'h0000, int'($urandom_range(0, 2)), sa, sw);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
